// File: rtl/bus_if_types_pkg.sv
// Shared types for the master_bus_if protocol.
//   ttype_e  : READ / WRITE transfer type
//   tsize_e  : funct3-coded access size; bit2 (unsigned) carries no meaning here.
//              Every 3-bit code is enumerated so raw funct3 values cast cleanly.
//   lane_be  : byte enables for a size at a byte lane
//   misaligned : true when a HALF/WORD access does not sit on its natural boundary
package bus_if_types_pkg;

  typedef enum logic {
    TT_READ  = 1'b0,
    TT_WRITE = 1'b1
  } ttype_e;

  typedef enum logic [2:0] {
    TS_BYTE  = 3'b000,
    TS_HALF  = 3'b001,
    TS_WORD  = 3'b010,
    TS_RSV3  = 3'b011,
    TS_BYTEU = 3'b100,
    TS_HALFU = 3'b101,
    TS_RSV6  = 3'b110,
    TS_RSV7  = 3'b111
  } tsize_e;

  // Low two bits decide the size: 00 byte, 01 half, 1x word (reserved codes act as word).
  function automatic logic [3:0] lane_be(input tsize_e ts, input logic [1:0] lane);
    case (ts[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input tsize_e ts, input logic [1:0] lane);
    case (ts[1:0])
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/master_bus_if.sv
// Core-to-memory bus driven by the rv32 core on ibus/dbus.
//   master modport : drives breq/bstart/ttype/tsize/addr/wdata, receives rdata/bdone
//   slave  modport : the reverse
interface master_bus_if;
  import bus_if_types_pkg::*;

  logic        breq;
  logic        bstart;
  ttype_e      ttype;
  tsize_e      tsize;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        bdone;

  modport master (output breq, bstart, ttype, tsize, addr, wdata,
                  input  rdata, bdone);
  modport slave  (input  breq, bstart, ttype, tsize, addr, wdata,
                  output rdata, bdone);
endinterface

// File: rtl/sram_array.sv
// Word-organised single-port SRAM, 32-bit words with byte enables.
//   clk   : clock
//   we    : write enable (byte-masked by be)
//   be    : byte enables, bit n covers wdata[8n+7:8n]
//   idx   : word index
//   wdata : write data, already steered to its lanes
//   rdata : registered read of mem[idx] (old contents on a write cycle)
// Contents are not reset.
module sram_array #(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = "",
  localparam int   IDXW      = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [3:0]      be,
  input  logic [IDXW-1:0] idx,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/bus_sram_slave.sv
// Slave end of master_bus_if in front of an on-chip SRAM.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : master_bus_if.slave (breq/bstart/ttype/tsize/addr/wdata in,
//                  rdata/bdone out)
//   misalign_err : sticky, set once a misaligned access has executed
// A request is accepted only from IDLE, optionally waits WAIT_STATES cycles,
// does one array access, then pulses bdone for one cycle with rdata valid.
// Read data is right-justified and zero-filled; write data arrives low-justified
// and is replicated across lanes so the byte enables pick the right bytes.
module bus_sram_slave
  import bus_if_types_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic       clk,
  input  logic       rst_n,
  master_bus_if.slave bus,
  output logic       misalign_err
);

  localparam int          IDXW    = $clog2(DEPTH);
  localparam logic [3:0]  WS      = 4'(WAIT_STATES);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q;
  logic [1:0]      lane_q;
  tsize_e          ts_q;
  logic            wr_q;
  logic            mis_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  // Word offset from the base; BASE_ADDR is aligned to the array size, so the
  // low IDXW bits of this difference are the word index.
  logic [29:0] woff;
  logic        hit, accept;
  assign woff   = bus.addr[31:2] - BASE_ADDR[31:2];
  assign hit    = bus.breq & bus.bstart & (woff < DEPTH_W);
  assign accept = (state_q == S_IDLE) & hit;

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          cnt_d   = WS;
          state_d = (WS != 4'd0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_RESP;
      // bstart is still high while the master samples bdone; ignore it here.
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Array access
  logic        arr_we;
  logic [3:0]  arr_be;
  logic [31:0] arr_wdata, arr_rdata;

  assign arr_we = (state_q == S_ACCESS) & wr_q & ~mis_q;
  assign arr_be = lane_be(ts_q, lane_q);

  always_comb begin
    case (ts_q[1:0])
      2'b00:   arr_wdata = {4{wdata_q[7:0]}};
      2'b01:   arr_wdata = {2{wdata_q[15:0]}};
      default: arr_wdata = wdata_q;
    endcase
  end

  sram_array #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (arr_be),
    .idx   (idx_q),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Read steering: array data lands in RESP; shift the addressed lane down and
  // zero everything above the access size.
  logic [31:0] rd_shift, rd_res;
  assign rd_shift = arr_rdata >> {lane_q, 3'b000};

  always_comb begin
    rd_res = '0;
    if ((state_q == S_RESP) && !wr_q && !mis_q) begin
      case (ts_q[1:0])
        2'b00:   rd_res = {24'h0, rd_shift[7:0]};
        2'b01:   rd_res = {16'h0, rd_shift[15:0]};
        default: rd_res = rd_shift;
      endcase
    end
  end

  // rdata_q keeps the last response visible after RESP.
  assign bus.rdata    = (state_q == S_RESP) ? rd_res : rdata_q;
  assign bus.bdone    = (state_q == S_RESP);
  assign misalign_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      ts_q    <= TS_BYTE;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= woff[IDXW-1:0];
        lane_q  <= bus.addr[1:0];
        ts_q    <= bus.tsize;
        wr_q    <= (bus.ttype == TT_WRITE);
        mis_q   <= misaligned(bus.tsize, bus.addr[1:0]);
        wdata_q <= bus.wdata;
      end
      if (state_q == S_RESP)              rdata_q <= rd_res;
      if ((state_q == S_ACCESS) && mis_q) err_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_sram_slave.sv
// Bench for bus_sram_slave: three instances (0, 3 and 5 wait states) share one
// stimulus bus, gated by sel so only the chosen instance sees requests.
module tb_bus_sram_slave;
  import bus_if_types_pkg::*;

  localparam logic [31:0] B = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        breq = 1'b0, bstart = 1'b0;
  ttype_e      tt = TT_READ;
  tsize_e      ts = TS_WORD;
  logic [31:0] addr = '0, wdata = '0;
  int          sel = 0;

  logic        bdone, err;
  logic [31:0] rdata;
  logic        err0, err1, err2;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  master_bus_if bif0();
  master_bus_if bif1();
  master_bus_if bif2();

  assign bif0.breq = breq & (sel == 0);  assign bif0.bstart = bstart & (sel == 0);
  assign bif1.breq = breq & (sel == 1);  assign bif1.bstart = bstart & (sel == 1);
  assign bif2.breq = breq & (sel == 2);  assign bif2.bstart = bstart & (sel == 2);
  assign bif0.ttype = tt; assign bif0.tsize = ts; assign bif0.addr = addr; assign bif0.wdata = wdata;
  assign bif1.ttype = tt; assign bif1.tsize = ts; assign bif1.addr = addr; assign bif1.wdata = wdata;
  assign bif2.ttype = tt; assign bif2.tsize = ts; assign bif2.addr = addr; assign bif2.wdata = wdata;

  bus_sram_slave #(.BASE_ADDR(B), .DEPTH(64), .WAIT_STATES(0), .INIT_FILE("")) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bif0), .misalign_err(err0));
  bus_sram_slave #(.BASE_ADDR(B), .DEPTH(64), .WAIT_STATES(3), .INIT_FILE("")) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bif1), .misalign_err(err1));
  bus_sram_slave #(.BASE_ADDR(B), .DEPTH(64), .WAIT_STATES(5), .INIT_FILE("")) u2 (
    .clk(clk), .rst_n(rst_n), .bus(bif2), .misalign_err(err2));

  always_comb begin
    case (sel)
      1:       begin bdone = bif1.bdone; rdata = bif1.rdata; err = err1; end
      2:       begin bdone = bif2.bdone; rdata = bif2.rdata; err = err2; end
      default: begin bdone = bif0.bdone; rdata = bif0.rdata; err = err0; end
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Wait for bdone (bounded); returns latency in cycles from the sampled
  // bstart cycle, or -1, and the rdata seen alongside bdone.
  task automatic wait_done(input int limit, output int lat, output logic [31:0] got);
    lat = -1;
    got = '0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (bdone) begin
        lat = c;
        got = rdata;
        break;
      end
    end
  endtask

  // One transfer. elat < 0 means the slave must not respond.
  task automatic txn(input string nm, input ttype_e t, input logic [2:0] s,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] er, input int elat);
    int          lat;
    logic [31:0] got, exp_rd;
    @(posedge clk); #1;
    breq = 1'b1; bstart = 1'b1; tt = t; ts = tsize_e'(s); addr = a; wdata = wd;
    if (elat >= 0) sb.push_back(er);
    wait_done(20, lat, got);
    if (elat < 0) begin
      chk({nm, " no-bdone"}, 32'(lat), 32'hFFFF_FFFF);
      breq = 1'b0; bstart = 1'b0;
    end else begin
      chk({nm, " latency"}, 32'(lat), 32'(elat));
      exp_rd = sb.pop_front();
      if (lat >= 0) chk({nm, " rdata"}, got, exp_rd);
      // master keeps bstart up through the bdone cycle, then drops it
      @(posedge clk); #1;
      breq = 1'b0; bstart = 1'b0;
      @(negedge clk);
      chk({nm, " single-pulse"}, {31'h0, bdone}, 32'h0);
    end
  endtask

  typedef struct {
    ttype_e      t;
    logic [2:0]  s;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int          lat, seen;
    logic [31:0] got, exp_rd;

    tbl[0]  = '{TT_WRITE, 3'b010, B + 0,   32'hDEAD_BEEF, 32'h0};
    tbl[1]  = '{TT_READ,  3'b010, B + 0,   32'h0,         32'hDEAD_BEEF};
    tbl[2]  = '{TT_WRITE, 3'b010, B + 8,   32'h1122_3344, 32'h0};
    tbl[3]  = '{TT_WRITE, 3'b000, B + 9,   32'h5555_55AA, 32'h0};
    tbl[4]  = '{TT_WRITE, 3'b001, B + 10,  32'h7777_BEEF, 32'h0};
    tbl[5]  = '{TT_READ,  3'b010, B + 8,   32'h0,         32'hBEEF_AA44};
    tbl[6]  = '{TT_READ,  3'b000, B + 11,  32'h0,         32'h0000_00BE};
    tbl[7]  = '{TT_READ,  3'b001, B + 8,   32'h0,         32'h0000_AA44};
    tbl[8]  = '{TT_READ,  3'b100, B + 9,   32'h0,         32'h0000_00AA};
    tbl[9]  = '{TT_READ,  3'b001, B + 10,  32'h0,         32'h0000_BEEF};
    tbl[10] = '{TT_READ,  3'b011, B + 8,   32'h0,         32'hBEEF_AA44};
    tbl[11] = '{TT_READ,  3'b000, B + 8,   32'h0,         32'h0000_0044};
    tbl[12] = '{TT_READ,  3'b101, B + 10,  32'h0,         32'h0000_BEEF};
    tbl[13] = '{TT_WRITE, 3'b010, B + 252, 32'h0102_0304, 32'h0};
    tbl[14] = '{TT_WRITE, 3'b000, B + 255, 32'h0000_005A, 32'h0};
    tbl[15] = '{TT_READ,  3'b001, B + 254, 32'h0,         32'h0000_5A02};

    // reset state of every instance
    #3;
    for (int k = 0; k < 3; k++) begin
      sel = k; #1;
      chk($sformatf("rst%0d bdone", k), {31'h0, bdone}, 32'h0);
      chk($sformatf("rst%0d rdata", k), rdata, 32'h0);
      chk($sformatf("rst%0d err", k), {31'h0, err}, 32'h0);
    end
    sel = 0;
    #12 rst_n = 1'b1;

    // zero wait states: table
    for (int i = 0; i < 16; i++)
      txn($sformatf("v%0d", i), tbl[i].t, tbl[i].s, tbl[i].a, tbl[i].wd, tbl[i].er, 2);
    @(negedge clk);
    chk("rdata hold", rdata, 32'h0000_5A02);
    chk("err clean", {31'h0, err}, 32'h0);

    // address decode misses
    txn("miss hi", TT_READ, 3'b010, B + 256, 32'h0, 32'h0, -1);
    txn("miss lo", TT_READ, 3'b010, B - 4,   32'h0, 32'h0, -1);

    // misaligned accesses complete, write nothing, return zero, set sticky flag
    txn("mis wr", TT_WRITE, 3'b001, B + 1, 32'h0000_1234, 32'h0, 2);
    chk("mis err set", {31'h0, err}, 32'h1);
    txn("mis chk", TT_READ, 3'b010, B + 0, 32'h0, 32'hDEAD_BEEF, 2);
    txn("mis rd",  TT_READ, 3'b010, B + 2, 32'h0, 32'h0, 2);
    txn("good rd", TT_READ, 3'b000, B + 8, 32'h0, 32'h0000_0044, 2);
    chk("mis err sticky", {31'h0, err}, 32'h1);

    // three wait states
    sel = 1;
    txn("ws3 wr", TT_WRITE, 3'b010, B + 0, 32'hCAFE_F00D, 32'h0, 5);
    txn("ws3 rd", TT_READ,  3'b010, B + 0, 32'h0, 32'hCAFE_F00D, 5);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bdone) seen++;
    end
    chk("ws3 no extra", 32'(seen), 32'h0);

    // bstart held continuously: second request starts only in the IDLE cycle
    @(posedge clk); #1;
    breq = 1'b1; bstart = 1'b1; tt = TT_READ; ts = TS_HALF; addr = B + 2; wdata = '0;
    sb.push_back(32'h0000_CAFE);
    wait_done(20, lat, got);
    chk("b2b first lat", 32'(lat), 32'd5);
    exp_rd = sb.pop_front();
    chk("b2b first rdata", got, exp_rd);
    @(posedge clk); #1;
    addr = B + 0;
    sb.push_back(32'h0000_F00D);
    wait_done(20, lat, got);
    chk("b2b second lat", 32'(lat), 32'd5);
    exp_rd = sb.pop_front();
    chk("b2b second rdata", got, exp_rd);
    @(posedge clk); #1;
    breq = 1'b0; bstart = 1'b0;

    // five wait states, reset during WAIT
    sel = 2;
    txn("ws5 wr", TT_WRITE, 3'b010, B + 16, 32'h0BAD_F00D, 32'h0, 7);
    txn("ws5 rd", TT_READ,  3'b010, B + 16, 32'h0, 32'h0BAD_F00D, 7);
    @(posedge clk); #1;
    breq = 1'b1; bstart = 1'b1; tt = TT_WRITE; ts = TS_WORD; addr = B + 16; wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    chk("ws5 pre-rst rdata", rdata, 32'h0BAD_F00D);
    #2 rst_n = 1'b0;
    #1;
    chk("ws5 rst bdone", {31'h0, bdone}, 32'h0);
    chk("ws5 rst rdata", rdata, 32'h0);
    sel = 0; #1;
    chk("rst clears err", {31'h0, err}, 32'h0);
    sel = 2;
    @(posedge clk); #1;
    breq = 1'b0; bstart = 1'b0;
    @(negedge clk);
    chk("ws5 in-rst bdone", {31'h0, bdone}, 32'h0);
    rst_n = 1'b1;
    txn("ws5 post-rst", TT_READ, 3'b010, B + 16, 32'h0, 32'h0BAD_F00D, 7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
